// File: rtl/memory_pkg.sv
// Shared memory-subsystem types: L1 D-Cache geometry and the d0 invalidate request.
package memory_pkg;

  localparam int unsigned DCACHE_L1_IDX_A_LEN = 6;

  typedef struct packed {
    logic                           valid;
    logic [DCACHE_L1_IDX_A_LEN-1:0] idx;
  } rst_l1dc_req_t;

endpackage

// File: rtl/dcache_l1_rst_block.sv
// L1 D-Cache invalidation sweeper: issues one invalidate per set to d0 after reset
// or on flush, gating LSQ/L2 traffic via l1dc_busy_o until the sweep completes.
module dcache_l1_rst_block
  import memory_pkg::*;
#(
  parameter int unsigned N_SETS  = 2**DCACHE_L1_IDX_A_LEN,
  parameter int unsigned IDX_LEN = DCACHE_L1_IDX_A_LEN
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  output rst_l1dc_req_t rst_l1dc_req_o,
  input  logic          rst_l1dc_req_rdy_i,
  output logic          l1dc_busy_o,
  output logic          sweep_done_o
);

  typedef enum logic [1:0] {
    S_SWEEP,
    S_DONE_PULSE,
    S_IDLE
  } state_e;

  localparam logic [IDX_LEN-1:0] LAST_IDX = IDX_LEN'(N_SETS - 1);

  state_e             state_q, state_d;
  logic [IDX_LEN-1:0] idx_q,   idx_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_SWEEP: begin
        // Flush wins over a same-cycle transfer: d0 still saw that request,
        // but the sweep restarts and the aborted one never signals done.
        if (flush_i) begin
          idx_d = '0;
        end else if (rst_l1dc_req_rdy_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE_PULSE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_LEN'(1);
          end
        end
      end
      S_DONE_PULSE: begin
        state_d = flush_i ? S_SWEEP : S_IDLE;
        idx_d   = '0;
      end
      S_IDLE: begin
        if (flush_i) state_d = S_SWEEP;
        idx_d = '0;
      end
      default: begin
        state_d = S_SWEEP;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_SWEEP;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs are pure decodes of the state/counter flops, so reset takes effect immediately.
  always_comb begin
    rst_l1dc_req_o.valid = (state_q == S_SWEEP);
    rst_l1dc_req_o.idx   = DCACHE_L1_IDX_A_LEN'(idx_q);
    l1dc_busy_o          = (state_q != S_IDLE);
    sweep_done_o         = (state_q == S_DONE_PULSE);
  end

endmodule

// File: tb/tb_dcache_l1_rst_block.sv
// Scoreboarded bench for dcache_l1_rst_block: per-cycle predictions from a set-sweep model.
module tb_dcache_l1_rst_block;
  import memory_pkg::*;

  localparam int unsigned NS = 64;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  rst_l1dc_req_t req_o;
  logic          rdy_i;
  logic          busy_o;
  logic          done_o;

  dcache_l1_rst_block #(.N_SETS(NS), .IDX_LEN(DCACHE_L1_IDX_A_LEN)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .flush_i           (flush_i),
    .rst_l1dc_req_o    (req_o),
    .rst_l1dc_req_rdy_i(rdy_i),
    .l1dc_busy_o       (busy_o),
    .sweep_done_o      (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int idx;
    bit busy;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   accepted = 0;
  int   dones = 0;

  // Reference model: is a sweep running, which set is next, is the completion being announced.
  bit sweeping;
  int next_set;
  bit announcing;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    sweeping   = 1'b1;
    next_set   = 0;
    announcing = 1'b0;
  endtask

  // One clock cycle: predict what the DUT presents now, then advance the model across the edge.
  task automatic cycle(input bit rdy, input bit flush);
    exp_t x;
    rdy_i   = rdy;
    flush_i = flush;
    x.valid = sweeping;
    x.idx   = sweeping ? next_set : 0;
    x.busy  = sweeping || announcing;
    x.done  = announcing;
    exp_q.push_back(x);
    if (sweeping) begin
      if (flush) next_set = 0;
      else if (rdy) begin
        if (next_set + 1 == NS) begin
          sweeping   = 1'b0;
          announcing = 1'b1;
          next_set   = 0;
        end else next_set = next_set + 1;
      end
    end else if (announcing) begin
      announcing = 1'b0;
      if (flush) sweeping = 1'b1;
    end else if (flush) begin
      sweeping = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("valid", int'(req_o.valid), int'(e.valid));
      check("busy", int'(busy_o), int'(e.busy));
      check("done", int'(done_o), int'(e.done));
      if (e.valid) check("idx", int'(req_o.idx), e.idx);
      if (req_o.valid && rdy_i) accepted++;
      if (done_o) dones++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(req_o.valid), 1);
    check({tag, "_idx"}, int'(req_o.idx), 0);
    check({tag, "_busy"}, int'(busy_o), 1);
    check({tag, "_done"}, int'(done_o), 0);
  endtask

  int d0;
  int a0;

  initial begin
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    rdy_i   = 1'b0;
    #3;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    model_reset();

    // Full sweep with rdy held high, then a few idle cycles.
    a0 = accepted;
    d0 = dones;
    for (int i = 0; i < NS + 4; i++) cycle(1'b1, 1'b0);
    check("sweep1_accepted", accepted - a0, NS);
    check("sweep1_dones", dones - d0, 1);

    // Flush from idle, then sweep under 1,0,0,1 backpressure.
    a0 = accepted;
    d0 = dones;
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 4 * NS + 8; i++) cycle((i % 3) == 0, 1'b0);
    check("bp_accepted", accepted - a0, NS);
    check("bp_dones", dones - d0, 1);

    // Flush at idx 20 mid-sweep, then let it complete.
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 200 && next_set != 20; i++) cycle(1'b1, 1'b0);
    check("reached_idx20", next_set, 20);
    d0 = dones;
    cycle(1'b1, 1'b1);
    for (int i = 0; i < NS + 4; i++) cycle(1'b1, 1'b0);
    check("flush20_dones", dones - d0, 1);

    // Flush coincident with the done pulse: sweep restarts with no idle cycle.
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 200 && !announcing; i++) cycle(1'b1, 1'b0);
    check("reached_done", int'(announcing), 1);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < NS + 4; i++) cycle(1'b1, 1'b0);

    // Asynchronous reset at idx 37, between clock edges.
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 200 && next_set != 37; i++) cycle(1'b1, 1'b0);
    check("reached_idx37", next_set, 37);
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("async");
    @(posedge clk);
    #1;
    check_reset_outputs("held");
    rst_ni = 1'b1;
    model_reset();
    d0 = dones;
    for (int i = 0; i < NS + 4; i++) cycle(1'b1, 1'b0);
    check("post_rst_dones", dones - d0, 1);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 4) != 0, ($urandom % 97) == 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
